// File: rtl/bcd_down_counter_pkg.sv
// Shared BCD definitions for the down counter and its per-digit slice.
package bcd_down_counter_pkg;
   localparam int unsigned BCD_DIGIT_W = 4;
   localparam logic [3:0]  BCD_MAX     = 4'd9;

   typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;
endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of the down counter: borrow-chained decrement and load-value sanitizing.
module bcd_down_digit
   import bcd_down_counter_pkg::*;
(
   input  bcd_digit_t digit_i,
   input  logic       borrow_in_i,
   input  bcd_digit_t raw_i,
   output bcd_digit_t digit_next_o,
   output logic       borrow_out_o,
   output bcd_digit_t sanitized_o
);

   always_comb begin
      digit_next_o = digit_i;
      borrow_out_o = 1'b0;
      if (borrow_in_i) begin
         if (digit_i == '0) begin
            digit_next_o = BCD_MAX;
            borrow_out_o = 1'b1;
         end else begin
            digit_next_o = digit_i - 4'd1;
         end
      end
   end

   // Hex digits A-F clamp to 9 so the count register only ever holds BCD.
   assign sanitized_o = (raw_i > BCD_MAX) ? BCD_MAX : raw_i;

endmodule

// File: rtl/bcd_down_counter.sv
// Cascadable multi-digit BCD down counter with wrap-to-9s or auto-reload at terminal count.
module bcd_down_counter
   import bcd_down_counter_pkg::*;
#(
   parameter int unsigned DIGITS = 2
) (
   input  logic                    CLK,
   input  logic                    Clear,
   input  logic [4*DIGITS-1:0]     Data_in,
   input  logic                    Load,
   input  logic                    Count,
   input  logic                    Reload_en,
   output logic [4*DIGITS-1:0]     A_count,
   output logic                    B_out,
   output logic                    Zero
);

   localparam int unsigned W = BCD_DIGIT_W * DIGITS;

   logic [W-1:0]    count_q, count_d;
   logic [W-1:0]    reload_q, reload_d;
   logic [W-1:0]    dec_val;
   logic [W-1:0]    clean_val;
   logic [DIGITS:0] borrow;
   logic            is_zero;

   assign borrow[0] = 1'b1;

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      bcd_down_digit u_digit (
         .digit_i      (count_q  [g*BCD_DIGIT_W +: BCD_DIGIT_W]),
         .borrow_in_i  (borrow[g]),
         .raw_i        (Data_in  [g*BCD_DIGIT_W +: BCD_DIGIT_W]),
         .digit_next_o (dec_val  [g*BCD_DIGIT_W +: BCD_DIGIT_W]),
         .borrow_out_o (borrow[g+1]),
         .sanitized_o  (clean_val[g*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
   end

   // A borrow escapes the top digit only when every digit is 0.
   assign is_zero = borrow[DIGITS];

   always_comb begin
      count_d  = count_q;
      reload_d = reload_q;
      if (Load) begin
         count_d  = clean_val;
         reload_d = clean_val;
      end else if (Count) begin
         if (is_zero) begin
            count_d = Reload_en ? reload_q : {DIGITS{BCD_MAX}};
         end else begin
            count_d = dec_val;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (Clear) begin
         count_q  <= '0;
         reload_q <= '0;
      end else begin
         count_q  <= count_d;
         reload_q <= reload_d;
      end
   end

   assign A_count = count_q;
   assign B_out   = Count & ~Load & is_zero;
   assign Zero    = is_zero;

endmodule

// File: tb/tb_bcd_down_counter.sv
// Self-checking bench for bcd_down_counter: vector table, corner sequences, cascade, random vs decimal model.
module tb_bcd_down_counter;

   logic       CLK;
   logic       Clear, Load, Count, Reload_en;
   logic [7:0] Data_in, casc_data;
   logic [7:0] A_count;
   logic       B_out, Zero;
   logic [3:0] lo_a, hi_a;
   logic       lo_b, hi_b, lo_z, hi_z;

   int n_cmp = 0;
   int n_bad = 0;

   bcd_down_counter #(.DIGITS(2)) dut (
      .CLK(CLK), .Clear(Clear), .Data_in(Data_in), .Load(Load), .Count(Count),
      .Reload_en(Reload_en), .A_count(A_count), .B_out(B_out), .Zero(Zero)
   );

   bcd_down_counter #(.DIGITS(1)) u_lo (
      .CLK(CLK), .Clear(Clear), .Data_in(casc_data[3:0]), .Load(Load), .Count(Count),
      .Reload_en(Reload_en), .A_count(lo_a), .B_out(lo_b), .Zero(lo_z)
   );

   bcd_down_counter #(.DIGITS(1)) u_hi (
      .CLK(CLK), .Clear(Clear), .Data_in(casc_data[7:4]), .Load(Load), .Count(lo_b),
      .Reload_en(Reload_en), .A_count(hi_a), .B_out(hi_b), .Zero(hi_z)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic       clr, ld, cnt, ren;
      logic [7:0] data;
      logic       exp_b;
      logic [7:0] exp_cnt;
   } vec_t;

   vec_t vecs[17];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic clr, input logic ld, input logic cnt, input logic ren,
                        input logic [7:0] d);
      Clear = clr; Load = ld; Count = cnt; Reload_en = ren; Data_in = d; casc_data = d;
   endtask

   function automatic logic [7:0] to_bcd(input int v);
      logic [7:0] r;
      r[7:4] = 4'(v / 10);
      r[3:0] = 4'(v % 10);
      return r;
   endfunction

   function automatic int san(input logic [7:0] d);
      int hi, lo;
      hi = int'(d[7:4]);
      lo = int'(d[3:0]);
      if (hi > 9) hi = 9;
      if (lo > 9) lo = 9;
      return hi * 10 + lo;
   endfunction

   int m_cnt, m_rel, exp_v, pulses;
   logic r_clr, r_ld, r_cnt, r_ren;
   logic [7:0] r_d;

   initial begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h47);

      //              clr ld cnt ren data   b  cnt
      vecs[0]  = '{1'b1,1'b1,1'b0,1'b0,8'h47,1'b0,8'h00};
      vecs[1]  = '{1'b1,1'b1,1'b0,1'b0,8'h47,1'b0,8'h00};
      vecs[2]  = '{1'b0,1'b0,1'b0,1'b0,8'h47,1'b0,8'h00};
      vecs[3]  = '{1'b0,1'b1,1'b0,1'b0,8'hA5,1'b0,8'h95};
      vecs[4]  = '{1'b0,1'b1,1'b0,1'b0,8'h3F,1'b0,8'h39};
      vecs[5]  = '{1'b0,1'b0,1'b1,1'b0,8'h00,1'b0,8'h38};
      vecs[6]  = '{1'b0,1'b1,1'b0,1'b0,8'h50,1'b0,8'h50};
      vecs[7]  = '{1'b0,1'b1,1'b1,1'b0,8'h20,1'b0,8'h20};
      vecs[8]  = '{1'b0,1'b0,1'b1,1'b0,8'h00,1'b0,8'h19};
      vecs[9]  = '{1'b0,1'b1,1'b0,1'b0,8'hC7,1'b0,8'h97};
      vecs[10] = '{1'b0,1'b1,1'b0,1'b0,8'h0F,1'b0,8'h09};
      vecs[11] = '{1'b0,1'b1,1'b0,1'b1,8'h00,1'b0,8'h00};
      vecs[12] = '{1'b0,1'b1,1'b1,1'b1,8'h00,1'b0,8'h00};
      vecs[13] = '{1'b0,1'b0,1'b1,1'b1,8'h00,1'b1,8'h00};
      vecs[14] = '{1'b0,1'b0,1'b1,1'b0,8'h00,1'b1,8'h99};
      vecs[15] = '{1'b1,1'b1,1'b1,1'b0,8'h55,1'b0,8'h00};
      vecs[16] = '{1'b1,1'b0,1'b1,1'b0,8'h00,1'b1,8'h00};

      for (int i = 0; i < 17; i++) begin
         @(negedge CLK);
         drive(vecs[i].clr, vecs[i].ld, vecs[i].cnt, vecs[i].ren, vecs[i].data);
         #1;
         if (i > 0) check($sformatf("vec%0d_bout", i), B_out, vecs[i].exp_b);
         @(posedge CLK); #1;
         check($sformatf("vec%0d_count", i), A_count, vecs[i].exp_cnt);
         check($sformatf("vec%0d_zero", i), Zero, vecs[i].exp_cnt == 8'h00);
      end

      // 12 down to 00, then wrap to 99
      @(negedge CLK); drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h12);
      for (int i = 0; i < 13; i++) begin
         @(negedge CLK); drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00); #1;
         check("wrap_seq_count", A_count, to_bcd(12 - i));
         check("wrap_seq_bout", B_out, (12 - i) == 0);
      end
      @(negedge CLK); drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00); #1;
      check("wrap_to_99", A_count, 8'h99);
      check("hold_no_bout", B_out, 1'b0);

      // auto-reload of 03
      @(negedge CLK); drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h03);
      pulses = 0;
      for (int i = 0; i < 9; i++) begin
         @(negedge CLK); drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h00); #1;
         exp_v = 3 - (i % 4);
         check("reload_seq_count", A_count, to_bcd(exp_v));
         check("reload_seq_bout", B_out, exp_v == 0);
         if (B_out) pulses++;
      end
      check("reload_pulses", pulses, 2);

      // two 1-digit stages cascaded against the 2-digit counter
      @(negedge CLK); drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h13);
      for (int i = 0; i < 14; i++) begin
         @(negedge CLK); drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h13); #1;
         exp_v = 13 - i;
         check("casc_dut_count", A_count, to_bcd(exp_v));
         check("casc_chain_count", {hi_a, lo_a}, to_bcd(exp_v));
         check("casc_lo_bout", lo_b, (exp_v % 10) == 0);
         check("casc_hi_bout", hi_b, exp_v == 0);
         check("casc_zero", lo_z & hi_z, exp_v == 0);
      end
      @(negedge CLK); drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00); #1;
      check("casc_dut_99", A_count, 8'h99);
      check("casc_chain_99", {hi_a, lo_a}, 8'h99);

      // random traffic against a decimal model
      @(negedge CLK); drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      @(posedge CLK);
      m_cnt = 0; m_rel = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge CLK);
         r_clr = ($urandom_range(0, 31) == 0);
         r_ld  = ($urandom_range(0, 7) == 0);
         r_cnt = ($urandom_range(0, 3) != 0);
         r_ren = 1'($urandom_range(0, 1));
         r_d   = 8'($urandom_range(0, 255));
         drive(r_clr, r_ld, r_cnt, r_ren, r_d);
         #1;
         check("rnd_bout", B_out, r_cnt && !r_ld && (m_cnt == 0));
         check("rnd_zero", Zero, m_cnt == 0);
         if (r_clr) begin
            m_cnt = 0; m_rel = 0;
         end else if (r_ld) begin
            m_cnt = san(r_d); m_rel = m_cnt;
         end else if (r_cnt) begin
            if (m_cnt == 0) m_cnt = r_ren ? m_rel : 99;
            else            m_cnt = m_cnt - 1;
         end
         @(posedge CLK); #1;
         check("rnd_count", A_count, to_bcd(m_cnt));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
